uart_fifo_ctrl: RTL and testbench

//  Parametrised synchronous FIFO for the UART TX/RX data paths. Replaces the fixed-capacity buffer.

---
 rtl/uart_fifo_ctrl_if.sv | 45 ++++
 rtl/uart_fifo_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_ctrl_if.sv
// Interface: uart_fifo_ctrl_if
// Purpose : Groups the data, handshake, status and error signals of the UART
//           FIFO controller. Clock and reset are not part of it; they stay plain
//           ports on the FIFO.
// Parameters:
//   WIDTH - data word width in bits
//   DEPTH - number of storage entries (must match the FIFO instance)
// Modports:
//   master - the user side (UART shifter / host register block). It drives
//            flush, data_i, push, pop, thr_i and clr_err_i.
//   slave  - the FIFO side. It drives data_o, full_o, empty_o, count_o,
//            thr_hit_o, overrun_o, underrun_o and peak_o.
interface uart_fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic [WIDTH-1:0] data_i;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_o;
  logic             full_o;
  logic             empty_o;
  logic [CNT_W-1:0] count_o;
  logic [CNT_W-1:0] thr_i;
  logic             thr_hit_o;
  logic             clr_err_i;
  logic             overrun_o;
  logic             underrun_o;
  logic [CNT_W-1:0] peak_o;

  modport master (
    output flush, data_i, push, pop, thr_i, clr_err_i,
    input  data_o, full_o, empty_o, count_o, thr_hit_o,
           overrun_o, underrun_o, peak_o
  );

  modport slave (
    input  flush, data_i, push, pop, thr_i, clr_err_i,
    output data_o, full_o, empty_o, count_o, thr_hit_o,
           overrun_o, underrun_o, peak_o
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Module : uart_fifo_ctrl
// Purpose: Parametrised synchronous first-word-fall-through FIFO for the UART
//          TX/RX data paths. All DEPTH entries are usable. It provides an
//          occupancy count, a programmable threshold flag, a synchronous flush,
//          and sticky overrun/underrun flags with an explicit clear.
// Parameters:
//   WIDTH - data word width in bits (>=1)
//   DEPTH - storage entries (>=2); need not be a power of two
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous reset, active-high; takes priority over all other inputs
//   bus   - uart_fifo_ctrl_if.slave bundle:
//           flush/push/pop/data_i/thr_i/clr_err_i in
//           data_o/full_o/empty_o/count_o/thr_hit_o/overrun_o/underrun_o/peak_o out
// Configuration:
//   UART_FIFO_PEAK_EN - when defined, peak_o is a high-water mark of count_o.
//                       Reset clears it; flush does not. When undefined, there
//                       is no peak logic and peak_o is tied to 0.
module uart_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_fifo_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;

  logic full, empty;
  logic wr_en, rd_en;
  logic overrun_set, underrun_set;

  // The wrap is explicit, so DEPTH does not have to be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A push into a full FIFO is still accepted if a pop frees a slot in the
  // same cycle. A pop on an empty FIFO is never accepted, even with a push.
  // Flush masks both requests and their error side effects.
  always_comb begin
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    overrun_set  = 1'b0;
    underrun_set = 1'b0;
    if (!bus.flush) begin
      wr_en        = bus.push && (!full || bus.pop);
      rd_en        = bus.pop && !empty;
      overrun_set  = bus.push && full && !bus.pop;
      underrun_set = bus.pop && empty;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // If a flag is set and cleared in the same cycle, the set wins, so the
  // event is never lost.
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (bus.clr_err_i) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (overrun_set)  overrun_d  = 1'b1;
    if (underrun_set) underrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.data_i;
  end

  assign bus.data_o     = mem_q[rd_ptr_q];
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.count_o    = count_q;
  assign bus.thr_hit_o  = (bus.thr_i != '0) && (count_q >= bus.thr_i);
  assign bus.overrun_o  = overrun_q;
  assign bus.underrun_o = underrun_q;

`ifdef UART_FIFO_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  // This tracks the registered count, so peak_o lags the rise by one cycle.
  always_comb begin
    peak_d = peak_q;
    if (count_q > peak_q) peak_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign bus.peak_o = peak_q;
`else
  assign bus.peak_o = '0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Testbench: tb_uart_fifo_ctrl
// Purpose  : Directed scoreboard bench for uart_fifo_ctrl. A DEPTH=16 instance
//            covers fill/drain, overrun, underrun, threshold and flush. A DEPTH=5
//            instance covers non-power-of-two pointer wrap. The stimulus queues
//            expected read data and expected status values. A negedge monitor
//            pops the queues and compares them against the DUT outputs.
//            Build with UART_FIFO_PEAK_EN to check the high-water mark.
module tb_uart_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int D5    = 5;

  typedef enum int {F_COUNT, F_FULL, F_EMPTY, F_THR, F_OVR, F_UDR, F_PEAK, F_DATA} field_e;

  typedef struct {
    string  name;
    int     dut;
    field_e field;
    int     value;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  exp_t             stat_q[$];
  logic [WIDTH-1:0] data_q[$];
  logic [WIDTH-1:0] data5_q[$];

  uart_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  uart_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(D5))    bus5 ();

  uart_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  uart_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(D5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  always #5 clk = ~clk;

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] sample(int d, field_e f);
    logic [31:0] r;
    r = '0;
    if (d == 0) begin
      case (f)
        F_COUNT: r = 32'(bus.count_o);
        F_FULL:  r = 32'(bus.full_o);
        F_EMPTY: r = 32'(bus.empty_o);
        F_THR:   r = 32'(bus.thr_hit_o);
        F_OVR:   r = 32'(bus.overrun_o);
        F_UDR:   r = 32'(bus.underrun_o);
        F_PEAK:  r = 32'(bus.peak_o);
        F_DATA:  r = 32'(bus.data_o);
        default: r = '0;
      endcase
    end else begin
      case (f)
        F_COUNT: r = 32'(bus5.count_o);
        F_FULL:  r = 32'(bus5.full_o);
        F_EMPTY: r = 32'(bus5.empty_o);
        F_THR:   r = 32'(bus5.thr_hit_o);
        F_OVR:   r = 32'(bus5.overrun_o);
        F_UDR:   r = 32'(bus5.underrun_o);
        F_PEAK:  r = 32'(bus5.peak_o);
        F_DATA:  r = 32'(bus5.data_o);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // The monitor runs at each negedge, away from the active edge. It checks the
  // head word whenever a pop is presented on a non-empty FIFO, then compares
  // every status expectation queued since the last negedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pop && !bus.empty_o) begin
        if (data_q.size() == 0) check_output("dut16 unexpected data word", 1, 0);
        else                    check_output("dut16 data_o", 32'(bus.data_o), 32'(data_q.pop_front()));
      end
      if (bus5.pop && !bus5.empty_o) begin
        if (data5_q.size() == 0) check_output("dut5 unexpected data word", 1, 0);
        else                     check_output("dut5 data_o", 32'(bus5.data_o), 32'(data5_q.pop_front()));
      end
    end
    while (stat_q.size() > 0) begin
      exp_t e;
      e = stat_q.pop_front();
      check_output(e.name, sample(e.dut, e.field), 32'(e.value));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expect_field(string name, int d, field_e f, int v);
    exp_t e;
    e.name  = name;
    e.dut   = d;
    e.field = f;
    e.value = v;
    stat_q.push_back(e);
  endtask

  // Drives one cycle of requests from posedge+1, holds them across the next
  // active edge, then returns the requests to idle.
  task automatic apply_stimulus(int d, bit p, bit q, logic [WIDTH-1:0] din, bit fl, bit clr);
    if (d == 0) begin
      bus.push = p; bus.pop = q; bus.data_i = din; bus.flush = fl; bus.clr_err_i = clr;
    end else begin
      bus5.push = p; bus5.pop = q; bus5.data_i = din; bus5.flush = fl; bus5.clr_err_i = clr;
    end
    @(posedge clk);
    #1;
    bus.push = 0;  bus.pop = 0;  bus.flush = 0;  bus.clr_err_i = 0;
    bus5.push = 0; bus5.pop = 0; bus5.flush = 0; bus5.clr_err_i = 0;
  endtask

  task automatic push_word(int d, logic [WIDTH-1:0] din);
    if (d == 0) data_q.push_back(din);
    else        data5_q.push_back(din);
    apply_stimulus(d, 1, 0, din, 0, 0);
  endtask

  task automatic pop_word(int d);
    apply_stimulus(d, 0, 1, '0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.push = 0;  bus.pop = 0;  bus.flush = 0;  bus.clr_err_i = 0;  bus.data_i = '0;  bus.thr_i = '0;
    bus5.push = 0; bus5.pop = 0; bus5.flush = 0; bus5.clr_err_i = 0; bus5.data_i = '0; bus5.thr_i = '0;
    data_q.delete();
    data5_q.delete();
    repeat (2) @(posedge clk);
    #1;
    expect_field("reset count_o",    0, F_COUNT, 0);
    expect_field("reset empty_o",    0, F_EMPTY, 1);
    expect_field("reset full_o",     0, F_FULL,  0);
    expect_field("reset thr_hit_o",  0, F_THR,   0);
    expect_field("reset overrun_o",  0, F_OVR,   0);
    expect_field("reset underrun_o", 0, F_UDR,   0);
    expect_field("reset peak_o",     0, F_PEAK,  0);
    expect_field("reset dut5 empty", 1, F_EMPTY, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Fill to capacity, then drain in order.
    for (int i = 0; i < 16; i++) push_word(0, WIDTH'(i));
    expect_field("fill count_o", 0, F_COUNT, 16);
    expect_field("fill full_o",  0, F_FULL,  1);
    expect_field("fill empty_o", 0, F_EMPTY, 0);
    for (int i = 0; i < 16; i++) pop_word(0);
    expect_field("drain empty_o", 0, F_EMPTY, 1);
    expect_field("drain count_o", 0, F_COUNT, 0);

    // A push into a full FIFO is dropped and raises overrun.
    for (int i = 0; i < 16; i++) push_word(0, WIDTH'(8'h10 + i));
    apply_stimulus(0, 1, 0, 8'hAA, 0, 0);
    expect_field("overrun set",          0, F_OVR,   1);
    expect_field("overrun count_o kept", 0, F_COUNT, 16);
    apply_stimulus(0, 0, 0, '0, 0, 1);
    expect_field("overrun cleared", 0, F_OVR, 0);
    apply_stimulus(0, 1, 0, 8'hAA, 0, 1);
    expect_field("overrun set beats clear", 0, F_OVR, 1);
    apply_stimulus(0, 0, 0, '0, 0, 1);
    expect_field("overrun cleared again", 0, F_OVR, 0);

    // Push and pop together on a full FIFO: both are accepted and no overrun.
    data_q.push_back(8'h55);
    apply_stimulus(0, 1, 1, 8'h55, 0, 0);
    expect_field("full push+pop overrun", 0, F_OVR,   0);
    expect_field("full push+pop count_o", 0, F_COUNT, 16);
    for (int i = 0; i < 16; i++) pop_word(0);
    expect_field("after 0x55 empty_o", 0, F_EMPTY, 1);

    // Underrun, then a push with a pop on an empty FIFO.
    pop_word(0);
    expect_field("underrun set",        0, F_UDR,   1);
    expect_field("underrun count_o",    0, F_COUNT, 0);
    apply_stimulus(0, 0, 0, '0, 0, 1);
    expect_field("underrun cleared",    0, F_UDR,   0);
    data_q.push_back(8'h3C);
    apply_stimulus(0, 1, 1, 8'h3C, 0, 0);
    expect_field("empty push+pop udr",   0, F_UDR,   1);
    expect_field("empty push+pop count", 0, F_COUNT, 1);
    expect_field("empty push+pop data",  0, F_DATA,  8'h3C);
    pop_word(0);
    expect_field("0x3C drained", 0, F_EMPTY, 1);

    // Threshold checks, starting from a fresh reset so the peak starts at 0.
    do_reset();
    bus.thr_i = 5'd4;
    push_word(0, 8'h01);
    push_word(0, 8'h02);
    push_word(0, 8'h03);
    expect_field("thr 3 of 4", 0, F_THR, 0);
    push_word(0, 8'h04);
    expect_field("thr 4 of 4", 0, F_THR, 1);
    pop_word(0);
    expect_field("thr after pop", 0, F_THR,   0);
    expect_field("thr pop count", 0, F_COUNT, 3);
    bus.thr_i = '0;
    push_word(0, 8'h05);
    expect_field("thr disabled at 4", 0, F_THR, 0);
    push_word(0, 8'h06);
    expect_field("five stored", 0, F_COUNT, 5);

    // Flush with a push in the same cycle. The push is discarded.
    data_q.delete();
    apply_stimulus(0, 1, 0, 8'h77, 1, 0);
    expect_field("flush count_o",  0, F_COUNT, 0);
    expect_field("flush empty_o",  0, F_EMPTY, 1);
    expect_field("flush overrun",  0, F_OVR,   0);
`ifdef UART_FIFO_PEAK_EN
    expect_field("peak after flush", 0, F_PEAK, 5);
`else
    expect_field("peak tied off",    0, F_PEAK, 0);
`endif
    apply_stimulus(0, 0, 1, '0, 1, 0);
    expect_field("flush masks underrun", 0, F_UDR, 0);

    // DEPTH=5: move the pointers to 3, then fill through the wrap and drain.
    for (int i = 0; i < 3; i++) push_word(1, WIDTH'(8'hA0 + i));
    for (int i = 0; i < 3; i++) pop_word(1);
    for (int i = 0; i < 5; i++) push_word(1, WIDTH'(8'hB0 + i));
    expect_field("dut5 full_o",  1, F_FULL,  1);
    expect_field("dut5 count_o", 1, F_COUNT, 5);
    apply_stimulus(1, 1, 0, 8'hCC, 0, 0);
    expect_field("dut5 overrun", 1, F_OVR, 1);
    for (int i = 0; i < 5; i++) pop_word(1);
    expect_field("dut5 empty_o", 1, F_EMPTY, 1);

    repeat (3) @(posedge clk);
    #1;
    check_output("dut16 leftover words", 32'(data_q.size()), 0);
    check_output("dut5 leftover words",  32'(data5_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
